// File: rtl/tl_d_channel_arbiter_if.sv
// TileLink D-channel bundle between NUM_IN packed requesters and one downstream response path.
interface tl_d_channel_arbiter_if #(
  parameter int NUM_IN = 4
);
  localparam int GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0]   io_in_valid;
  logic [NUM_IN-1:0]   io_in_ready;
  logic [3*NUM_IN-1:0] io_in_bits_opcode;
  logic [4*NUM_IN-1:0] io_in_bits_size;
  logic [7*NUM_IN-1:0] io_in_bits_source;

  logic                io_out_ready;
  logic                io_out_valid;
  logic [2:0]          io_out_bits_opcode;
  logic [3:0]          io_out_bits_size;
  logic [6:0]          io_out_bits_source;
  logic                io_out_last;
  logic [GW-1:0]       io_out_grant;

  modport slave (
    input  io_in_valid,
    input  io_in_bits_opcode,
    input  io_in_bits_size,
    input  io_in_bits_source,
    input  io_out_ready,
    output io_in_ready,
    output io_out_valid,
    output io_out_bits_opcode,
    output io_out_bits_size,
    output io_out_bits_source,
    output io_out_last,
    output io_out_grant
  );

  modport master (
    output io_in_valid,
    output io_in_bits_opcode,
    output io_in_bits_size,
    output io_in_bits_source,
    output io_out_ready,
    input  io_in_ready,
    input  io_out_valid,
    input  io_out_bits_opcode,
    input  io_out_bits_size,
    input  io_out_bits_source,
    input  io_out_last,
    input  io_out_grant
  );
endinterface

// File: rtl/tl_d_channel_arbiter.sv
// Round-robin arbiter sharing one TileLink D-channel response path among NUM_IN requesters.
// Define TL_D_ARB_BURST_LOCK_EN to hold the grant across multi-beat data bursts.
module tl_d_channel_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int BEAT_BYTES = 8
) (
  input logic                   clock,
  input logic                   reset,
  tl_d_channel_arbiter_if.slave io
);
  localparam int            GW       = $clog2(NUM_IN);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_IN - 1);

  if ((NUM_IN < 2) || (NUM_IN > 8) || (BEAT_BYTES < 4) || (BEAT_BYTES > 64) ||
      ((BEAT_BYTES & (BEAT_BYTES - 1)) != 0)) begin : g_param_check
    $error("tl_d_channel_arbiter: unsupported NUM_IN or BEAT_BYTES");
  end

  logic [GW-1:0]     rr_ptr_q;
  logic [GW-1:0]     rr_ptr_d;
  logic [GW-1:0]     rr_grant_s;
  logic [GW-1:0]     grant_s;
  logic [GW-1:0]     grant_inc_s;
  logic              sel_valid_s;
  logic [2:0]        sel_opcode_s;
  logic [3:0]        sel_size_s;
  logic [6:0]        sel_source_s;
  logic [NUM_IN-1:0] in_ready_s;
  logic              accept_s;

  // Round-robin pick: the valid requester closest above rr_ptr (wrapping) wins.
  always_comb begin
    rr_grant_s = {GW{1'b0}};
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (io.io_in_valid[i] && (i == ((int'(rr_ptr_q) + k) % NUM_IN))) begin
          rr_grant_s = GW'(i);
        end else begin
          rr_grant_s = rr_grant_s;
        end
      end
    end
  end

  // Datapath mux driven by the current grant.
  always_comb begin
    sel_valid_s  = 1'b0;
    sel_opcode_s = 3'd0;
    sel_size_s   = 4'd0;
    sel_source_s = 7'd0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_s == GW'(i)) begin
        sel_valid_s  = io.io_in_valid[i];
        sel_opcode_s = io.io_in_bits_opcode[3*i +: 3];
        sel_size_s   = io.io_in_bits_size[4*i +: 4];
        sel_source_s = io.io_in_bits_source[7*i +: 7];
      end else begin
        sel_valid_s  = sel_valid_s;
      end
    end
  end

  // Only the granted requester sees downstream ready.
  always_comb begin
    in_ready_s = {NUM_IN{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready_s[i] = io.io_out_ready & (grant_s == GW'(i));
    end
  end

  assign accept_s    = sel_valid_s & io.io_out_ready;
  assign grant_inc_s = (grant_s == LAST_IDX) ? {GW{1'b0}} : grant_s + GW'(1);

`ifdef TL_D_ARB_BURST_LOCK_EN
  localparam int            LOG_BB  = $clog2(BEAT_BYTES);
  localparam int            CW      = 16 - LOG_BB;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic [GW-1:0] lock_grant_q;
  logic [GW-1:0] lock_grant_d;
  logic [CW-1:0] beats_left_q;
  logic [CW-1:0] beats_left_d;
  logic          sel_multi_s;
  logic [3:0]    shamt_s;
  logic [CW-1:0] sel_beats_m1_s;
  logic          last_s;

  // Beats above one per beat-width: only AccessAckData / GrantData larger than a beat.
  assign sel_multi_s    = ((sel_opcode_s == 3'd1) || (sel_opcode_s == 3'd5)) &&
                          (sel_size_s > 4'(LOG_BB));
  assign shamt_s        = sel_size_s - 4'(LOG_BB);
  assign sel_beats_m1_s = (CNT_ONE << shamt_s) - CNT_ONE;

  // Grant is combinational while idle and latched for the whole burst.
  always_comb begin
    grant_s = rr_grant_s;
    case (state_q)
      ST_IDLE:   grant_s = rr_grant_s;
      ST_LOCKED: grant_s = lock_grant_q;
      default:   grant_s = rr_grant_s;
    endcase
  end

  // Last-beat flag for the beat currently presented.
  always_comb begin
    last_s = 1'b0;
    case (state_q)
      ST_IDLE:   last_s = ~sel_multi_s;
      ST_LOCKED: last_s = (beats_left_q == CNT_ONE);
      default:   last_s = 1'b0;
    endcase
  end

  // Next state: lock on a multi-beat first beat, release after the final beat.
  always_comb begin
    state_d      = state_q;
    lock_grant_d = lock_grant_q;
    beats_left_d = beats_left_q;
    rr_ptr_d     = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && sel_multi_s) begin
          state_d      = ST_LOCKED;
          lock_grant_d = grant_s;
          beats_left_d = sel_beats_m1_s;
        end else if (accept_s) begin
          rr_ptr_d     = grant_inc_s;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (accept_s && (beats_left_q == CNT_ONE)) begin
          state_d      = ST_IDLE;
          beats_left_d = {CW{1'b0}};
          rr_ptr_d     = grant_inc_s;
        end else if (accept_s) begin
          beats_left_d = beats_left_q - CNT_ONE;
        end else begin
          state_d      = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Burst state registers; reset abandons any partial burst.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      lock_grant_q <= {GW{1'b0}};
      beats_left_q <= {CW{1'b0}};
    end else begin
      state_q      <= state_d;
      lock_grant_q <= lock_grant_d;
      beats_left_q <= beats_left_d;
    end
  end

  assign io.io_out_last = last_s;
`else
  assign grant_s = rr_grant_s;

  // Every accepted beat re-arbitrates and advances the pointer.
  always_comb begin
    if (accept_s) begin
      rr_ptr_d = grant_inc_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  assign io.io_out_last = 1'b1;
`endif

  // Round-robin pointer register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= {GW{1'b0}};
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign io.io_in_ready        = in_ready_s;
  assign io.io_out_valid       = sel_valid_s;
  assign io.io_out_bits_opcode = sel_opcode_s;
  assign io.io_out_bits_size   = sel_size_s;
  assign io.io_out_bits_source = sel_source_s;
  assign io.io_out_grant       = grant_s;

endmodule
